// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: bundles the host request, shift-register control and
// SPI pad signals of the SPI mode-0 master sequencer.
//   master modport : the sequencer's view (drives sclk/ss_n/mosi, sr_*, status)
//   slave modport  : the peer view (host request logic, shift register, pads)
// Signals:
//   start, div           host transfer request and SCLK half-period minus one
//   sr_load, sr_shift    shift register load / shift strobes
//   sr_top               shift register MSB
//   miso                 synchronised serial input from the slave
//   sclk, ss_n, mosi     SPI pads
//   busy, done, rx_data  status and received word
interface spi_master_ctrl_if #(
  parameter int CHAR_LENGTH = 8,
  parameter int DIV_WIDTH   = 8
);
  logic                   start;
  logic [DIV_WIDTH-1:0]   div;
  logic                   sr_load;
  logic                   sr_shift;
  logic                   sr_top;
  logic                   miso;
  logic                   sclk;
  logic                   ss_n;
  logic                   mosi;
  logic                   busy;
  logic                   done;
  logic [CHAR_LENGTH-1:0] rx_data;

  modport master (
    input  start, div, sr_top, miso,
    output sr_load, sr_shift, sclk, ss_n, mosi, busy, done, rx_data
  );

  modport slave (
    output start, div, sr_top, miso,
    input  sr_load, sr_shift, sclk, ss_n, mosi, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master sequencer. Generates SCLK (idle low) and
// the active-low slave select, strobes the external transmit shift register
// (load on start acceptance, shift on each SCLK fall except after the last
// bit), samples MISO on SCLK rises MSB first and reports completion with a
// one-cycle done pulse.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  spi_master_ctrl_if.master (start/div in, sr_load/sr_shift out,
//        sr_top/miso in, sclk/ss_n/mosi out, busy/done/rx_data out)
// Parameters CHAR_LENGTH and DIV_WIDTH must match the interface instance.
module spi_master_ctrl #(
  parameter int CHAR_LENGTH = 8,
  parameter int DIV_WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.master  bus
);

  localparam int BW = $clog2(CHAR_LENGTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAR_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic [DIV_WIDTH-1:0]   cnt_r, cnt_s;
  logic [DIV_WIDTH-1:0]   div_r, div_s;
  logic [BW-1:0]          bit_r, bit_s;
  logic [CHAR_LENGTH-1:0] rx_shift_r, rx_shift_s;
  logic [CHAR_LENGTH-1:0] rx_data_r, rx_data_s;
  logic                   sclk_r, sclk_s;
  logic                   ss_n_r, ss_n_s;
  logic                   done_r, done_s;
  logic                   load_s, shift_s, sample_s, expire_s;

  // The half-period counter runs only outside IDLE and is compared against
  // the divider latched at acceptance, so mid-transfer div changes are inert.
  assign expire_s = (state_r != IDLE) && (cnt_r == div_r);

  // Next-state, next register values and strobe decode.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    sclk_s    = sclk_r;
    ss_n_s    = ss_n_r;
    done_s    = 1'b0;
    rx_data_s = rx_data_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    sample_s  = 1'b0;

    if (state_r == IDLE || expire_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + 1'b1;
    end

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = LEAD;
          load_s  = 1'b1;
          div_s   = bus.div;
          bit_s   = '0;
          ss_n_s  = 1'b0;
        end else begin
          ss_n_s  = 1'b1;
        end
      end
      LEAD, LOW: begin
        if (expire_s) begin
          state_s  = HIGH;
          sclk_s   = 1'b1;
          sample_s = 1'b1;
        end else begin
          state_s  = state_r;
        end
      end
      HIGH: begin
        if (expire_s) begin
          sclk_s = 1'b0;
          if (bit_r == LAST_BIT) begin
            state_s = TRAIL;
          end else begin
            state_s = LOW;
            bit_s   = bit_r + 1'b1;
            shift_s = 1'b1;
          end
        end else begin
          state_s = HIGH;
        end
      end
      TRAIL: begin
        if (expire_s) begin
          state_s   = IDLE;
          done_s    = 1'b1;
          rx_data_s = rx_shift_r;
          // A request already pending keeps the slave selected so a
          // back-to-back word (accepted in the done cycle) sees no ss_n gap.
          ss_n_s    = ~bus.start;
        end else begin
          state_s   = TRAIL;
        end
      end
      default: begin
        state_s = IDLE;
        sclk_s  = 1'b0;
        ss_n_s  = 1'b1;
      end
    endcase

    if (sample_s) begin
      rx_shift_s = {rx_shift_r[CHAR_LENGTH-2:0], bus.miso};
    end else begin
      rx_shift_s = rx_shift_r;
    end
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      div_r      <= '0;
      bit_r      <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      sclk_r     <= 1'b0;
      ss_n_r     <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_r      <= div_s;
      bit_r      <= bit_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      sclk_r     <= sclk_s;
      ss_n_r     <= ss_n_s;
      done_r     <= done_s;
    end
  end

  assign bus.sr_load  = load_s & ~rst;
  assign bus.sr_shift = shift_s;
  assign bus.mosi     = bus.sr_top & ~ss_n_r;
  assign bus.sclk     = sclk_r;
  assign bus.ss_n     = ss_n_r;
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = done_r;
  assign bus.rx_data  = rx_data_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed self-checking bench for spi_master_ctrl with an
// 8-bit instance (main scenarios) and a 16-bit instance (length scaling).
// The bench models the external shift register and the slave's MISO source.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.CHAR_LENGTH(8),  .DIV_WIDTH(8)) bus ();
  spi_master_ctrl_if #(.CHAR_LENGTH(16), .DIV_WIDTH(8)) bus2 ();

  spi_master_ctrl #(.CHAR_LENGTH(8),  .DIV_WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master_ctrl #(.CHAR_LENGTH(16), .DIV_WIDTH(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int passes = 0;
  int total  = 0;

  logic [7:0]  d_in = 8'h00;
  logic [7:0]  sr;
  logic [7:0]  pat = 8'h00;
  logic [15:0] d_in2 = 16'h0000;
  logic [15:0] sr2;
  int          miso_mode = 0;
  int          base = 0;
  int          idx;

  int   rises = 0, shifts = 0, loads = 0, ssn_rises = 0, hi_cycles = 0;
  logic sclk_q = 1'b0, ssn_q = 1'b1;
  logic [7:0] mosi_cap = 8'h00;
  int   rises2 = 0, shifts2 = 0;
  logic sclk2_q = 1'b0;

  // Transmit shift register model for the 8-bit instance.
  always @(posedge clk or posedge rst) begin
    if (rst) sr <= 8'h00;
    else if (bus.sr_load) sr <= d_in;
    else if (bus.sr_shift) sr <= {sr[6:0], 1'b0};
  end
  assign bus.sr_top = sr[7];

  // Transmit shift register model for the 16-bit instance.
  always @(posedge clk or posedge rst) begin
    if (rst) sr2 <= 16'h0000;
    else if (bus2.sr_load) sr2 <= d_in2;
    else if (bus2.sr_shift) sr2 <= {sr2[14:0], 1'b0};
  end
  assign bus2.sr_top = sr2[15];
  assign bus2.miso   = bus2.mosi;

  // MISO source: loopback, constant one, or a pattern indexed by rises seen.
  assign idx = rises - base;
  always_comb begin
    bus.miso = 1'b0;
    case (miso_mode)
      0: bus.miso = bus.mosi;
      1: bus.miso = 1'b1;
      2: if (idx >= 0 && idx < 8) bus.miso = pat[3'(7 - idx)];
      default: bus.miso = 1'b0;
    endcase
  end

  // Mid-cycle event counters for both instances.
  always @(negedge clk) begin
    sclk_q  <= bus.sclk;
    ssn_q   <= bus.ss_n;
    sclk2_q <= bus2.sclk;
    if (bus.sclk && !sclk_q) begin
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[6:0], bus.mosi};
    end
    if (bus.sr_shift) shifts <= shifts + 1;
    if (bus.sr_load) loads <= loads + 1;
    if (bus.ss_n && !ssn_q) ssn_rises <= ssn_rises + 1;
    if (bus.sclk) hi_cycles <= hi_cycles + 1;
    if (bus2.sclk && !sclk2_q) rises2 <= rises2 + 1;
    if (bus2.sr_shift) shifts2 <= shifts2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit transfer; lat = edges after the accepting edge until done.
  task automatic xfer(input logic [7:0] data, input logic [7:0] dv, input logic [7:0] dv_after,
                      input bit hold, output int lat);
    d_in      = data;
    bus.div   = dv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.div = dv_after;
    if (!hold) bus.start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 400);
  endtask

  int lat, r0, s0, l0, n0, h0;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.div    = 8'd0;
    bus2.start = 1'b0;
    bus2.div   = 8'd0;
    #3;
    chk("rst_sr_load", 32'(bus.sr_load), 32'h0);
    chk("rst_sr_shift", 32'(bus.sr_shift), 32'h0);
    chk("rst_sclk", 32'(bus.sclk), 32'h0);
    chk("rst_ss_n", 32'(bus.ss_n), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_rx", 32'(bus.rx_data), 32'h0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Loopback 0xA5 at div=0.
    miso_mode = 0;
    r0 = rises; s0 = shifts; l0 = loads; n0 = ssn_rises;
    xfer(8'hA5, 8'd0, 8'd0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd17);
    chk("t1_rises", 32'(rises - r0), 32'd8);
    chk("t1_shifts", 32'(shifts - s0), 32'd7);
    chk("t1_loads", 32'(loads - l0), 32'd1);
    chk("t1_ssn_rises", 32'(ssn_rises - n0), 32'd0);
    chk("t1_rx", 32'(bus.rx_data), 32'hA5);
    chk("t1_mosi", 32'(mosi_cap), 32'hA5);
    chk("t1_ss_n_done", 32'(bus.ss_n), 32'h1);
    chk("t1_busy_done", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus.done), 32'h0);
    chk("t1_rx_hold", 32'(bus.rx_data), 32'hA5);

    // div=3, MISO high, div dropped to 0 mid-transfer.
    miso_mode = 1;
    r0 = rises; h0 = hi_cycles;
    xfer(8'h00, 8'd3, 8'd0, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd68);
    chk("t2_rx", 32'(bus.rx_data), 32'hFF);
    chk("t2_hi_cycles", 32'(hi_cycles - h0), 32'd32);
    chk("t2_rises", 32'(rises - r0), 32'd8);
    @(posedge clk); #1;

    // Start held high, back-to-back word accepted in the done cycle.
    miso_mode = 0;
    l0 = loads; n0 = ssn_rises;
    xfer(8'h81, 8'd0, 8'd0, 1'b1, lat);
    chk("t3_latency1", 32'(lat), 32'd17);
    chk("t3_loads1", 32'(loads - l0), 32'd1);
    chk("t3_rx1", 32'(bus.rx_data), 32'h81);
    chk("t3_ss_n_low", 32'(bus.ss_n), 32'h0);
    xfer(8'h7E, 8'd0, 8'd0, 1'b0, lat);
    chk("t3_latency2", 32'(lat), 32'd17);
    chk("t3_loads2", 32'(loads - l0), 32'd2);
    chk("t3_rx2", 32'(bus.rx_data), 32'h7E);
    chk("t3_mosi2", 32'(mosi_cap), 32'h7E);
    chk("t3_ssn_rises", 32'(ssn_rises - n0), 32'd0);
    @(posedge clk); #1;

    // Reset after three SCLK rises.
    r0 = rises;
    d_in = 8'hFF; bus.div = 8'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while ((rises - r0) < 3 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t4_three_rises", 32'(rises - r0), 32'd3);
    chk("t4_busy_before", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_sclk", 32'(bus.sclk), 32'h0);
    chk("t4_ss_n", 32'(bus.ss_n), 32'h1);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    chk("t4_done", 32'(bus.done), 32'h0);
    chk("t4_rx", 32'(bus.rx_data), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(bus.done), 32'h0);
    chk("t4_rx_after", 32'(bus.rx_data), 32'h0);
    xfer(8'h5A, 8'd0, 8'd0, 1'b0, lat);
    chk("t4_fresh_latency", 32'(lat), 32'd17);
    chk("t4_fresh_rx", 32'(bus.rx_data), 32'h5A);
    @(posedge clk); #1;

    // Independent MISO pattern 0x3C while transmitting 0xC3.
    miso_mode = 2;
    pat = 8'h3C;
    base = rises;
    xfer(8'hC3, 8'd0, 8'd0, 1'b0, lat);
    chk("t5_rx", 32'(bus.rx_data), 32'h3C);
    chk("t5_mosi", 32'(mosi_cap), 32'hC3);
    @(posedge clk); #1;

    // 16-bit instance, div=1, loopback.
    r0 = rises2; s0 = shifts2;
    d_in2 = 16'hBEEF; bus2.div = 8'd1; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus2.done && lat < 400);
    chk("t6_latency", 32'(lat), 32'd66);
    chk("t6_rises", 32'(rises2 - r0), 32'd16);
    chk("t6_shifts", 32'(shifts2 - s0), 32'd15);
    chk("t6_rx", 32'(bus2.rx_data), 32'hBEEF);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 master sequencer for the transmit shift register. It generates SCLK and the active-low slave select, and pulses the register's `load` and `shift` controls at the correct edges. It also deserialises MISO into a receive word and reports completion with a one-cycle `done` pulse. It sits between the host-side transfer request logic and the shift register / SPI pads.

## Interface
- `CHAR_LENGTH`, 8: bits per transfer, ≥2; must equal the shift register width.
- `DIV_WIDTH`, 8: width of the clock-divider setting.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: transfer request, sampled only when `busy`=0. Upstream holds the shift register's `d_in` valid while `start` is high.
- `div` in DIV_WIDTH: SCLK half-period minus one, in clk cycles. Latched on start acceptance.
- `sr_load` out 1: drives the shift register's `load` input.
- `sr_shift` out 1: drives the shift register's `shift` input.
- `sr_top` in 1: MSB output of the shift register.
- `miso` in 1: serial data from the slave, already synchronised.
- `sclk` out 1: SPI clock, idle low.
- `ss_n` out 1: slave select, active low.
- `mosi` out 1: serial data to the slave.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at transfer end.
- `rx_data` out CHAR_LENGTH: last received word.

## Operation
States are IDLE, LEAD, HIGH, LOW and TRAIL. A half-period counter (DIV_WIDTH bits) expires after `div_q`+1 cycles in each non-IDLE state, then reloads. A bit counter of $clog2(CHAR_LENGTH) bits counts completed bits.

**Combinational outputs**
- `sr_load` = `start` & (state==IDLE) & !`rst`. The shift register captures `d_in` on the accepting edge.
- `sr_shift` = (state==HIGH) & counter expiry & (bit_cnt ≠ CHAR_LENGTH-1).
- `mosi` = `sr_top` & !`ss_n`.

**State transitions**
- IDLE → LEAD on start acceptance:
  - `div_q` ← `div`, bit_cnt ← 0, `ss_n` ← 0.
- LEAD, expiry → HIGH:
  - `sclk` ← 1.
  - rx_shift ← {rx_shift[N-2:0], `miso`}, i.e. MISO is sampled on the rising edge, MSB first.
- HIGH, expiry, bit_cnt < N-1 → LOW:
  - `sclk` ← 0, bit_cnt++.
  - `sr_shift` pulse; the next bit appears on `mosi` at the falling edge.
- HIGH, expiry, bit_cnt = N-1 → TRAIL:
  - `sclk` ← 0, no shift.
- LOW, expiry → HIGH:
  - `sclk` ← 1, sample `miso` as above.
- TRAIL, expiry → IDLE:
  - `ss_n` ← 1, `done` ← 1 for one cycle.
  - `rx_data` ← rx_shift.

**Boundary conditions**
- `start` while `busy`=1 is ignored: no `sr_load`, and `div` changes have no effect mid-transfer.
- `start` in the `done` cycle is accepted, because the state is already IDLE. `ss_n` then stays low continuously, with a LEAD half-period before the next word.
- `div`=0 gives SCLK = clk/2. `div`=all-ones gives 2^DIV_WIDTH-cycle half-periods. The counter never wraps mid-half-period.
- `rx_data` changes only at the `done` edge and holds between transfers.

**Reset (including mid-transfer)**
- State goes to IDLE.
- Outputs: `sclk`=0, `ss_n`=1, `busy`=0, `done`=0, `rx_data`=0, `sr_load`=0, `sr_shift`=0.
- Internal: counters=0, rx_shift=0, `div_q`=0.
- No partial word is reported.

## Timing
- Let H=`div_q`+1 and N=CHAR_LENGTH. E0 is the accepting edge.
- `ss_n` falls at E0.
- The first SCLK rise is at E0+H.
- N SCLK rising edges occur, spaced 2H apart.
- `ss_n` rises, and `done` is high, during the cycle following edge E0+(2N+1)H.
- For N=8, H=1: `done` follows edge E0+17, with `busy` high 17 cycles.
- SCLK duty cycle is exactly 50%, with no glitches. `sclk`, `ss_n`, `done` and `rx_data` are registered.
- MOSI bit k is valid from the falling edge (or E0 for k=0) through the next rising edge, giving H cycles of setup and H cycles of hold.
- `sr_shift` pulses exactly N-1 times per transfer. `sr_load` pulses once.

## Test plan
- N=8, `div`=0, shift register loaded 0xA5, `miso` looped from `mosi` → `rx_data`=0xA5. Expect 8 SCLK rises, 7 `sr_shift` pulses, `done` one cycle after edge E0+17, `ss_n` low throughout.
- `div`=3, `miso` tied 1 → SCLK high 4 / low 4 cycles, `done` after edge E0+68, `rx_data`=0xFF. `div` changed to 0 mid-transfer has no effect.
- `start` held high for the whole transfer → only one `sr_load` before `done`. A second transfer starts in the `done` cycle; `ss_n` never rises between words.
- `rst` asserted after 3 SCLK rises → immediate `sclk`=0, `ss_n`=1, `busy`=0, no `done`, `rx_data`=0. A fresh `start` afterwards completes normally.
- `miso` driven 0x3C pattern MSB-first, independent of `mosi` → `rx_data`=0x3C. `mosi` sequence matches the loaded word MSB-first.
- CHAR_LENGTH=16, `div`=1 → 16 SCLK rises, 15 shifts, `done` after edge E0+66.
